ext_bus_responder: RTL and testbench

- Target (memory-side) end of the multiplexed 16-bit external SRAM bus driven by the CPU front-end initiator.
- Demultiplexes the two address phases (ALE0 low half, ALE1 high half + BLE) and the data phase (WE/OE/BHE).
- Issues one word/byte request per bus transaction to a back-end memory port and returns read data onto the shared bus with its own drive enable.
- Used as the on-FPGA SRAM model / memory-mapped peripheral target.

---
 rtl/ext_bus_responder.sv | 198 +++++++++++++++++++
 tb/tb_ext_bus_responder.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ext_bus_responder.sv
// ext_bus_responder: memory-side target of the multiplexed 16-bit external
// SRAM bus. Demultiplexes ALE0 (low address), ALE1 (high address + BLE) and
// the data phase, issues one back-end request per bus transaction and drives
// read data back onto the shared bus.
//
// Back-end handshake (mem_valid/mem_ready): the responder raises mem_valid
// with mem_rw/mem_addr/mem_wdata/mem_wmask and holds all of them stable until
// it samples mem_ready=1 on a rising clk edge; that edge is the single
// transfer point, and mem_valid is low from the following cycle. mem_rdata
// is only looked at on the transfer edge of a read. mem_ready may already be
// high in the first cycle mem_valid is high.
//
// dbg_state encoding: 0=IDLE 1=ADDR_HI 2=WDATA 3=MREQ 4=DRIVE.
module ext_bus_responder #(
  parameter int TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] bus_din,
  output logic [15:0] bus_dout,
  output logic        bus_drive,
  input  logic        ale0,
  input  logic        ale1,
  input  logic        we,
  input  logic        oe,
  input  logic        bhe,
  output logic        mem_valid,
  output logic        mem_rw,
  output logic [31:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic [1:0]  mem_wmask,
  input  logic        mem_ready,
  input  logic [15:0] mem_rdata,
  output logic        err,
  output logic [2:0]  dbg_state
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ADDR_HI = 3'd1,
    S_WDATA   = 3'd2,
    S_MREQ    = 3'd3,
    S_DRIVE   = 3'd4
  } state_t;

  state_t        r_state;
  logic [15:0]   r_lo;
  logic [14:0]   r_hi;
  logic          r_ble;
  logic [CW-1:0] r_cnt;
  logic [15:0]   r_bus_dout;
  logic          r_bus_drive;
  logic          r_mem_valid;
  logic          r_mem_rw;
  logic [15:0]   r_mem_wdata;
  logic [1:0]    r_mem_wmask;
  logic          r_err;

  logic          w_timeout;
  logic [1:0]    w_wmask;

  // Waiting phases give up once the counter has reached TIMEOUT-1.
  assign w_timeout = (r_cnt == CW'(TIMEOUT - 1));
  assign w_wmask   = {bhe, r_ble};

  // Single FSM: phase tracking, address/data capture, back-end request and
  // bus drive, all registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_lo        <= '0;
      r_hi        <= '0;
      r_ble       <= 1'b0;
      r_cnt       <= '0;
      r_bus_dout  <= '0;
      r_bus_drive <= 1'b0;
      r_mem_valid <= 1'b0;
      r_mem_rw    <= 1'b0;
      r_mem_wdata <= '0;
      r_mem_wmask <= '0;
      r_err       <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (ale0) begin
            r_lo    <= bus_din;
            r_cnt   <= '0;
            r_state <= S_ADDR_HI;
          end
        end

        S_ADDR_HI: begin
          if (ale0) begin
            // Initiator restarted the transaction: take the new low half.
            r_lo  <= bus_din;
            r_cnt <= '0;
          end else if (ale1) begin
            r_hi  <= bus_din[14:0];
            r_ble <= bus_din[15];
            r_cnt <= '0;
            if (we && !oe) begin
              r_state <= S_WDATA;
            end else if (oe && !we) begin
              r_mem_valid <= 1'b1;
              r_mem_rw    <= 1'b0;
              r_mem_wmask <= 2'b11;
              r_state     <= S_MREQ;
            end else begin
              r_err   <= 1'b1;
              r_state <= S_IDLE;
            end
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        S_WDATA: begin
          // Write data always arrives the cycle after ALE1, so this phase
          // never has to wait.
          if (ale0) begin
            r_lo    <= bus_din;
            r_cnt   <= '0;
            r_state <= S_ADDR_HI;
          end else begin
            r_mem_wdata <= bus_din;
            r_mem_wmask <= w_wmask;
            if (w_wmask == 2'b00) begin
              r_err   <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_mem_valid <= 1'b1;
              r_mem_rw    <= 1'b1;
              r_state     <= S_MREQ;
            end
          end
        end

        S_MREQ: begin
          // Back-end is trusted: no timeout, and ALE0 waits for completion.
          if (mem_ready) begin
            r_mem_valid <= 1'b0;
            if (r_mem_rw) begin
              r_state <= S_IDLE;
            end else begin
              r_bus_dout  <= mem_rdata;
              r_bus_drive <= 1'b1;
              r_cnt       <= '0;
              r_state     <= S_DRIVE;
            end
          end
        end

        S_DRIVE: begin
          if (ale0) begin
            r_bus_drive <= 1'b0;
            r_lo        <= bus_din;
            r_cnt       <= '0;
            r_state     <= S_ADDR_HI;
          end else if (we) begin
            // Never fight the initiator for the bus.
            r_bus_drive <= 1'b0;
            r_err       <= 1'b1;
            r_state     <= S_IDLE;
          end else if (!oe) begin
            r_bus_drive <= 1'b0;
            r_state     <= S_IDLE;
          end else if (w_timeout) begin
            r_bus_drive <= 1'b0;
            r_bus_dout  <= '0;
            r_err       <= 1'b1;
            r_state     <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus_dout  = r_bus_dout;
  assign bus_drive = r_bus_drive;
  assign mem_valid = r_mem_valid;
  assign mem_rw    = r_mem_rw;
  assign mem_addr  = {r_hi, r_lo, 1'b0};
  assign mem_wdata = r_mem_wdata;
  assign mem_wmask = r_mem_wmask;
  assign err       = r_err;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_ext_bus_responder.sv
// Testbench for ext_bus_responder: directed bus transactions plus a random
// mix, checked against a transaction-level model of the bus rules.
module tb_ext_bus_responder;

  localparam int TIMEOUT = 8;
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ADDR_HI = 3'd1;
  localparam int RW = 51;  // {rw, addr[31:0], wdata[15:0], wmask[1:0]}

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] bus_din = '0;
  logic [15:0] bus_dout;
  logic        bus_drive;
  logic        ale0 = 1'b0, ale1 = 1'b0, we = 1'b0, oe = 1'b0, bhe = 1'b0;
  logic        mem_valid, mem_rw;
  logic [31:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [1:0]  mem_wmask;
  logic        mem_ready = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic        err;
  logic [2:0]  dbg_state;

  int tests = 0;
  int fails = 0;

  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] got_q[$];

  int          ready_delay = 0;
  int          bk_wait = 0;
  logic [15:0] bk_rdata = '0;
  logic [RW-1:0] bk_cap = '0;

  ext_bus_responder #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .bus_din(bus_din), .bus_dout(bus_dout),
    .bus_drive(bus_drive), .ale0(ale0), .ale1(ale1), .we(we), .oe(oe),
    .bhe(bhe), .mem_valid(mem_valid), .mem_rw(mem_rw), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .err(err), .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed hang required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference address rule: byte address of the 16-bit word {hi[14:0], lo}.
  function automatic logic [31:0] addr_of(input logic [15:0] lo, input logic [15:0] hiword);
    return (32'(hiword & 16'h7fff) * 32'd131072) + (32'(lo) * 32'd2);
  endfunction

  // Back-end memory port: answers after ready_delay extra cycles and logs
  // every completed request; checks the request is held while waiting.
  always @(negedge clk) begin
    if (rst || !mem_valid) begin
      mem_ready = 1'b0;
      bk_wait   = 0;
    end else if (!mem_ready) begin
      if (bk_wait == 0)
        bk_cap = {mem_rw, mem_addr, mem_wdata, mem_wmask};
      else
        chk("req_stable", 64'({mem_rw, mem_addr, mem_wdata, mem_wmask}), 64'(bk_cap));
      if (bk_wait >= ready_delay) begin
        mem_ready = 1'b1;
        mem_rdata = bk_rdata;
        got_q.push_back({mem_rw, mem_addr, (mem_rw ? mem_wdata : 16'h0), mem_wmask});
      end else begin
        bk_wait++;
      end
    end else begin
      mem_ready = 1'b0;
      bk_wait   = 0;
    end
  end

  // driver tasks
  task automatic addr_phases(input logic [15:0] lo, input logic [15:0] hiword,
                             input logic we_v, input logic oe_v);
    ale0 = 1'b1; bus_din = lo;
    tick();
    ale0 = 1'b0; ale1 = 1'b1; we = we_v; oe = oe_v; bus_din = hiword;
    tick();
    ale1 = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (mem_valid && n < 50) begin
      tick();
      n++;
    end
    chk({tag, "_done"}, 64'(mem_valid), 64'(0));
  endtask

  task automatic data_phase(input logic [15:0] lo, input logic [15:0] hiword,
                            input logic [15:0] data, input logic bhe_v);
    logic [1:0] mask;
    mask = {bhe_v, hiword[15]};
    bus_din = data; bhe = bhe_v;
    tick();
    we = 1'b0; bhe = 1'b0; bus_din = '0;
    if (mask == 2'b00) begin
      chk("wr_nomask_err", 64'(err), 64'(1));
      chk("wr_nomask_novalid", 64'(mem_valid), 64'(0));
      tick();
      chk("wr_nomask_pulse", 64'(err), 64'(0));
      chk("wr_nomask_novalid2", 64'(mem_valid), 64'(0));
    end else begin
      chk("wr_valid", 64'(mem_valid), 64'(1));
      chk("wr_rw", 64'(mem_rw), 64'(1));
      chk("wr_addr", 64'(mem_addr), 64'(addr_of(lo, hiword)));
      chk("wr_wdata", 64'(mem_wdata), 64'(data));
      chk("wr_wmask", 64'(mem_wmask), 64'(mask));
      chk("wr_noerr", 64'(err), 64'(0));
      exp_q.push_back({1'b1, addr_of(lo, hiword), data, mask});
      wait_done("wr");
    end
  endtask

  task automatic do_write(input logic [15:0] lo, input logic [15:0] hiword,
                          input logic [15:0] data, input logic bhe_v);
    addr_phases(lo, hiword, 1'b1, 1'b0);
    data_phase(lo, hiword, data, bhe_v);
  endtask

  task automatic do_read(input logic [15:0] lo, input logic [15:0] hiword,
                         input logic [15:0] rdata, input int hold);
    bk_rdata = rdata;
    addr_phases(lo, hiword, 1'b0, 1'b1);
    bus_din = '0;
    chk("rd_valid", 64'(mem_valid), 64'(1));
    chk("rd_rw", 64'(mem_rw), 64'(0));
    chk("rd_wmask", 64'(mem_wmask), 64'(2'b11));
    chk("rd_addr", 64'(mem_addr), 64'(addr_of(lo, hiword)));
    chk("rd_nodrive_mreq", 64'(bus_drive), 64'(0));
    exp_q.push_back({1'b0, addr_of(lo, hiword), 16'h0, 2'b11});
    wait_done("rd");
    chk("rd_drive", 64'(bus_drive), 64'(1));
    chk("rd_dout", 64'(bus_dout), 64'(rdata));
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("rd_drive_hold", 64'(bus_drive), 64'(1));
    end
    oe = 1'b0;
    tick();
    chk("rd_drive_off", 64'(bus_drive), 64'(0));
    chk("rd_idle", 64'(dbg_state), 64'(ST_IDLE));
  endtask

  task automatic check_reqs();
    logic [RW-1:0] e, g;
    chk("req_count", 64'(got_q.size()), 64'(exp_q.size()));
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      chk("req_fields", 64'(g), 64'(e));
    end
    exp_q.delete();
    got_q.delete();
  endtask

  // directed sequence followed by random transactions
  initial begin
    logic [15:0] lo, hiw, dat;
    logic        b;
    int          kind;

    rst = 1'b1;
    tick();
    tick();
    chk("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    chk("rst_valid", 64'(mem_valid), 64'(0));
    chk("rst_addr", 64'(mem_addr), 64'(0));
    chk("rst_drive", 64'(bus_drive), 64'(0));
    chk("rst_dout", 64'(bus_dout), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    rst = 1'b0;
    tick();

    // write low byte only
    do_write(16'h1234, 16'h8005, 16'hABCD, 1'b0);
    chk("wr1_addr_lit", 64'(got_q.size() > 0 ? got_q[0][49:18] : 32'h0), 64'(32'h000A2468));
    check_reqs();

    // zero-wait read
    ready_delay = 0;
    do_read(16'h0010, 16'h0001, 16'h5A5A, 2);
    chk("rd1_dout_lit", 64'(bus_dout), 64'(16'h5A5A));
    check_reqs();

    // we and oe together in the address-high phase
    addr_phases(16'h4444, 16'h0002, 1'b1, 1'b1);
    we = 1'b0; oe = 1'b0;
    chk("weoe_err", 64'(err), 64'(1));
    chk("weoe_novalid", 64'(mem_valid), 64'(0));
    chk("weoe_idle", 64'(dbg_state), 64'(ST_IDLE));
    tick();
    chk("weoe_pulse", 64'(err), 64'(0));
    chk("weoe_novalid2", 64'(mem_valid), 64'(0));

    // write with both byte enables low
    do_write(16'h0100, 16'h0003, 16'h1111, 1'b0);
    check_reqs();

    // timeout waiting for ALE1
    ale0 = 1'b1; bus_din = 16'h7777;
    tick();
    ale0 = 1'b0; bus_din = '0;
    for (int i = 1; i <= TIMEOUT; i++) begin
      tick();
      chk("to_err", 64'(err), 64'(i == TIMEOUT));
    end
    chk("to_idle", 64'(dbg_state), 64'(ST_IDLE));
    tick();
    chk("to_pulse", 64'(err), 64'(0));
    do_read(16'h0222, 16'h0004, 16'hC0DE, 1);
    check_reqs();

    // ALE0 restart during the write data phase
    ale0 = 1'b1; bus_din = 16'h1000;
    tick();
    ale0 = 1'b0; ale1 = 1'b1; we = 1'b1; bus_din = 16'h8009;
    tick();
    ale1 = 1'b0; ale0 = 1'b1; bus_din = 16'h2000;
    tick();
    chk("restart_noerr", 64'(err), 64'(0));
    chk("restart_state", 64'(dbg_state), 64'(ST_ADDR_HI));
    chk("restart_novalid", 64'(mem_valid), 64'(0));
    ale0 = 1'b0; ale1 = 1'b1; we = 1'b1; bus_din = 16'h8009;
    tick();
    ale1 = 1'b0;
    data_phase(16'h2000, 16'h8009, 16'h55AA, 1'b1);
    check_reqs();

    // reset while the back-end is stalled
    ready_delay = 100;
    addr_phases(16'h3030, 16'h8006, 1'b1, 1'b0);
    bus_din = 16'h9999; bhe = 1'b1;
    tick();
    we = 1'b0; bhe = 1'b0; bus_din = '0;
    chk("rstm_valid", 64'(mem_valid), 64'(1));
    tick();
    rst = 1'b1;
    tick();
    chk("rstm_valid_off", 64'(mem_valid), 64'(0));
    chk("rstm_addr", 64'(mem_addr), 64'(0));
    chk("rstm_wdata", 64'(mem_wdata), 64'(0));
    chk("rstm_wmask", 64'(mem_wmask), 64'(0));
    chk("rstm_rw", 64'(mem_rw), 64'(0));
    chk("rstm_state", 64'(dbg_state), 64'(ST_IDLE));
    rst = 1'b0;
    tick();
    chk("rstm_noreq", 64'(got_q.size()), 64'(0));
    got_q.delete();

    // back-to-back writes, slow back-end
    ready_delay = 3;
    do_write(16'hA000, 16'h8010, 16'h0F0F, 1'b1);
    do_write(16'hA002, 16'h0010, 16'hF0F0, 1'b1);
    check_reqs();

    // random mix
    for (int n = 0; n < 20; n++) begin
      kind = $urandom_range(0, 2);
      lo   = 16'($urandom);
      hiw  = 16'($urandom);
      dat  = 16'($urandom);
      ready_delay = $urandom_range(0, 3);
      case (kind)
        0: begin
          b = hiw[15] ? 1'($urandom_range(0, 1)) : 1'b1;
          do_write(lo, hiw, dat, b);
        end
        1: do_read(lo, hiw, dat, $urandom_range(0, 3));
        default: begin
          hiw[15] = 1'b0;
          do_write(lo, hiw, dat, 1'b0);
        end
      endcase
    end
    check_reqs();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
